// File: rtl/run_ctrl.sv
// Purpose : sequences a run of cfg_a operations to a datapath, with cfg_b idle cycles between them.
// Latency : first op_valid one cycle after start is sampled; all outputs are registered.
// Backpres: op_valid/op_index hold until op_ready; with RUN_CTRL_TIMEOUT_EN a long stall aborts the run.
//
// Ports
//   clk, rst            : clock; synchronous active-high reset
//   start               : one-cycle run request (honoured only in IDLE or DONE)
//   cfg_a, cfg_b        : operation count and inter-operation gap, latched with start
//   op_valid, op_index  : operation offer and its zero-based index (index reads 0 when not valid)
//   op_ready            : datapath accepts the offered operation
//   busy, done, timeout : run in progress / run complete / run aborted by stall timeout
//
// Optional feature macro: RUN_CTRL_TIMEOUT_EN
//   defined   -> stall counter aborts the run after TIMEOUT consecutive stalled ISSUE cycles
//   undefined -> no stall counter, timeout is tied to 0, ISSUE waits on op_ready forever

module run_ctrl #(
  parameter int CW      = 32,
  parameter int TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] cfg_a,
  input  logic [CW-1:0] cfg_b,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [CW-1:0] op_index,
  output logic          busy,
  output logic          done,
  output logic          timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [CW-1:0] ONE = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] a_q, a_d;          // latched operation count
  logic [CW-1:0] b_q, b_d;          // latched gap length
  logic [CW-1:0] idx_q, idx_d;      // index of the operation being offered
  logic [CW-1:0] gap_q, gap_d;      // cycles already spent in GAP
  logic          valid_q, valid_d;
  logic [CW-1:0] index_q, index_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Comparing against A-1 (never computing idx+1 == A) keeps A = 2^CW-1
  // free of wrap: idx never needs to exceed A-1.
  logic last_op;
  logic gap_end;
  assign last_op = (idx_q == (a_q - ONE));
  assign gap_end = (gap_q == (b_q - ONE));

`ifdef RUN_CTRL_TIMEOUT_EN
  localparam logic [CW-1:0] STALL_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] stall_q, stall_d;  // consecutive stalled ISSUE cycles
  logic          to_q, to_d;
`else
  // TIMEOUT only matters when the stall timeout is compiled in.
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT == 0);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    valid_d = valid_q;
    index_d = index_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef RUN_CTRL_TIMEOUT_EN
    stall_d = stall_q;
    to_d    = to_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d   = cfg_a;
          b_d   = cfg_b;
          idx_d = '0;
          gap_d = '0;
`ifdef RUN_CTRL_TIMEOUT_EN
          stall_d = '0;
          to_d    = 1'b0;
`endif
          if (cfg_a != '0) begin
            state_d = ISSUE;
            valid_d = 1'b1;
            index_d = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end else begin
            // Empty run: straight to DONE, busy never rises.
            state_d = DONE;
            valid_d = 1'b0;
            index_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      ISSUE: begin
        if (op_ready) begin
`ifdef RUN_CTRL_TIMEOUT_EN
          stall_d = '0;
`endif
          if (last_op) begin
            state_d = DONE;
            valid_d = 1'b0;
            index_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + ONE;
            if (b_q == '0) begin
              // Back-to-back: offer the next operation immediately.
              index_d = idx_q + ONE;
            end else begin
              state_d = GAP;
              gap_d   = '0;
              valid_d = 1'b0;
              index_d = '0;
            end
          end
        end
`ifdef RUN_CTRL_TIMEOUT_EN
        else if (stall_q == STALL_LAST) begin
          // This cycle is the TIMEOUT-th consecutive stall: abort.
          state_d = DONE;
          stall_d = '0;
          valid_d = 1'b0;
          index_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          to_d    = 1'b1;
        end else begin
          stall_d = stall_q + ONE;
        end
`endif
      end

      GAP: begin
        // Entered with gap_q = 0, so leaving at gap_q = B-1 gives exactly B cycles.
        if (gap_end) begin
          state_d = ISSUE;
          gap_d   = '0;
          valid_d = 1'b1;
          index_d = idx_q;
        end else begin
          gap_d = gap_q + ONE;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        index_d = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      index_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RUN_CTRL_TIMEOUT_EN
      stall_q <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      index_q <= index_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef RUN_CTRL_TIMEOUT_EN
      stall_q <= stall_d;
      to_q    <= to_d;
`endif
    end
  end

  assign op_valid = valid_q;
  assign op_index = index_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef RUN_CTRL_TIMEOUT_EN
  assign timeout  = to_q;
`else
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed vector table, hand-written multi-cycle sequences,
// then randomized traffic compared against a run-level reference model.

module tb_run_ctrl;

  localparam int CW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cfg_a = '0;
  logic [CW-1:0] cfg_b = '0;
  logic          op_ready = 1'b0;
  logic          op_valid;
  logic [CW-1:0] op_index;
  logic          busy;
  logic          done;
  logic          timeout;

  int n_checks = 0;
  int n_err    = 0;

  run_ctrl #(.CW(CW), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_a    (cfg_a),
    .cfg_b    (cfg_b),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_index (op_index),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          r;
    logic          s;
    logic [CW-1:0] a;
    logic [CW-1:0] b;
    logic          rdy;
    logic          v;
    logic [CW-1:0] idx;
    logic          bz;
    logic          dn;
  } vec_t;

  vec_t vecs[15];

  task automatic drive(input logic r, input logic s, input logic [CW-1:0] a,
                       input logic [CW-1:0] b, input logic rdy);
    rst = r; start = s; cfg_a = a; cfg_b = b; op_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic v, input logic [CW-1:0] idx,
                     input logic bz, input logic dn, input logic to);
    n_checks++;
    if ({op_valid, op_index, busy, done, timeout} !== {v, idx, bz, dn, to}) begin
      n_err++;
      $display("FAIL %s: got v=%b idx=%0d busy=%b done=%b to=%b, want v=%b idx=%0d busy=%b done=%b to=%b",
               name, op_valid, op_index, busy, done, timeout, v, idx, bz, dn, to);
    end
  endtask

  // Reference model: a run is a list of A operations; each is offered until
  // accepted, and after each non-final acceptance B idle cycles follow.
  bit m_run, m_done, m_to;
  int m_A, m_B, m_k, m_gap_left, m_stall;

  task automatic model_reset();
    m_run = 0; m_done = 0; m_to = 0;
    m_A = 0; m_B = 0; m_k = 0; m_gap_left = 0; m_stall = 0;
  endtask

  task automatic model_step(input logic r, input logic s, input logic [CW-1:0] a,
                            input logic [CW-1:0] b, input logic rdy);
    if (r) begin
      model_reset();
    end else if (!m_run) begin
      if (s) begin
        m_A = int'(a); m_B = int'(b); m_k = 0; m_gap_left = 0; m_stall = 0;
        m_to = 0;
        m_run  = (m_A != 0);
        m_done = (m_A == 0);
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
    end else if (rdy) begin
      m_stall = 0;
      if (m_k == m_A - 1) begin
        m_run = 0; m_done = 1;
      end else begin
        m_k++;
        m_gap_left = m_B;
      end
    end else begin
`ifdef RUN_CTRL_TIMEOUT_EN
      m_stall++;
      if (m_stall == TO) begin
        m_run = 0; m_done = 1; m_to = 1; m_stall = 0;
      end
`endif
    end
  endtask

  task automatic model_chk(input string name);
    logic ev;
    ev = m_run && (m_gap_left == 0);
    chk(name, ev, ev ? CW'(m_k) : '0, m_run, m_done, m_to);
  endtask

  initial begin
    // Directed vectors: inputs applied for one edge, outputs expected after it.
    //            r     s     a      b      rdy   v     idx    busy  done
    vecs[0]  = '{1'b0, 1'b1, 4'd3, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 4'd0, 4'd7, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 4'd2, 4'd4, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 4'd9, 4'd9, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};

    // Reset state.
    drive(1'b1, 1'b1, 4'd3, 4'd0, 1'b1);
    tick();
    chk("reset", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].rdy);
      tick();
      chk($sformatf("vec%0d", i), vecs[i].v, vecs[i].idx, vecs[i].bz, vecs[i].dn, 1'b0);
    end

    // Stall at index 2 for 5 cycles; a start pulse mid-run is ignored.
    drive(1'b0, 1'b1, 4'd4, 4'd0, 1'b1);
    tick(); chk("stall_i0", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    tick(); chk("stall_i1", 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    tick(); chk("stall_i2", 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, (i == 2), 4'd9, 4'd3, 1'b0);
      tick();
      chk($sformatf("stall_hold%0d", i), 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    tick(); chk("stall_i3", 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    tick(); chk("stall_done", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

    // Reset mid-run, together with start, then a clean new run.
    drive(1'b0, 1'b1, 4'd5, 4'd0, 1'b1);
    tick(); chk("rstrun_i0", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    tick(); chk("rstrun_i1", 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 4'd5, 4'd0, 1'b1);
    tick(); chk("rstrun_rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("rstrun_quiet%0d", i), 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b1, 4'd2, 4'd1, 1'b1);
    tick(); chk("rerun_i0", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    tick(); chk("rerun_gap", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    tick(); chk("rerun_i1", 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    tick(); chk("rerun_done", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

    // Maximum count and maximum gap: A = B = 2^CW-1.
    drive(1'b0, 1'b1, 4'd15, 4'd0, 1'b1);
    tick(); chk("maxa_i0", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    for (int k = 1; k < 15; k++) begin
      tick(); chk($sformatf("maxa_i%0d", k), 1'b1, CW'(k), 1'b1, 1'b0, 1'b0);
    end
    tick(); chk("maxa_done", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 4'd2, 4'd15, 1'b1);
    tick(); chk("maxb_i0", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    for (int g = 0; g < 15; g++) begin
      tick(); chk($sformatf("maxb_gap%0d", g), 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    end
    tick(); chk("maxb_i1", 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    tick(); chk("maxb_done", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

    // Long stall at index 1: aborts after TO stalled cycles only with the timeout built in.
    drive(1'b0, 1'b1, 4'd3, 4'd0, 1'b1);
    tick(); chk("to_i0", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    tick(); chk("to_i1", 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
`ifdef RUN_CTRL_TIMEOUT_EN
    for (int i = 1; i < TO; i++) begin
      tick(); chk($sformatf("to_stall%0d", i), 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    end
    tick(); chk("to_abort", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    tick(); chk("to_held", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 4'd1, 4'd0, 1'b1);
    tick(); chk("to_restart", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    tick(); chk("to_cleardone", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
`else
    for (int i = 0; i < 3 * TO; i++) begin
      tick(); chk($sformatf("nto_stall%0d", i), 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    tick(); chk("nto_i2", 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    tick(); chk("nto_done", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
`endif

    // Randomized traffic against the reference model.
    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    tick();
    model_reset();
    model_chk("rand_reset");
    begin
      bit long_stall;
      logic r, s, rdy;
      logic [CW-1:0] a, b;
      long_stall = 0;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 149) == 0) long_stall = !long_stall;
        r   = ($urandom_range(0, 99) == 0);
        s   = ($urandom_range(0, 5) == 0);
        a   = ($urandom_range(0, 9) == 0) ? 4'd15 : CW'($urandom_range(0, 5));
        b   = CW'($urandom_range(0, 3));
        rdy = long_stall ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) != 0);
        drive(r, s, a, b, rdy);
        tick();
        model_step(r, s, a, b, rdy);
        model_chk($sformatf("rand%0d", c));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
